// File: rtl/gam_memory_bank_pkg.sv
// gam_memory_bank_pkg
// Shared types and constants for the GAM memory bank and its users.
//   rd_wr_t          : legacy read/write strobe type, kept for older users
//   gam_op_e         : request opcode (READ, WRITE, ALLOC, CLEAR)
//   FM_X..FM_M       : bit positions inside the 5-bit field-select mask
//   gam_bank_state_e : sequencing states of the bank controller
//   gam_node_t       : node record {X, W, Th, M} at the default geometry
package gam_memory_bank_pkg;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } rd_wr_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ALLOC = 2'd2,
        OP_CLEAR = 2'd3
    } gam_op_e;

    // Field-select mask layout {M, T, W, C, X}.
    localparam int FM_X    = 0;
    localparam int FM_C    = 1;
    localparam int FM_W    = 2;
    localparam int FM_T    = 3;
    localparam int FM_M    = 4;
    localparam int FM_BITS = 5;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_CLR  = 2'd2
    } gam_bank_state_e;

    // Default geometry of one node record. Banks built with other DIM/DATA_W
    // values declare the same layout locally from their own parameters.
    localparam int GAM_DIM    = 4;
    localparam int GAM_DATA_W = 16;

    typedef struct packed {
        logic [GAM_DIM*GAM_DATA_W-1:0] x;
        logic [GAM_DIM*GAM_DATA_W-1:0] w;
        logic [GAM_DATA_W-1:0]         th;
        logic [GAM_DATA_W-1:0]         m;
    } gam_node_t;

endpackage

// File: rtl/gam_bank_fsm.sv
// gam_bank_fsm
// Sequencing for the GAM memory bank: the power-up/reset INIT sweep over
// every class/node entry, the IDLE request window and the CLR sweep over the
// nodes of one class.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_valid    : request valid from the client
//   req_op       : request opcode
//   class_ok     : requested class index is inside the bank
//   req_ready    : bank can accept a request this cycle (IDLE only)
//   accept       : request handshake completes this cycle
//   init_busy    : INIT sweep writes entry {sweep_class, sweep_node}
//   clr_busy     : CLR sweep writes node sweep_node of the class being cleared
//   clr_done     : last CLR cycle, response is due on the next edge
//   sweep_class  : class index of the current sweep step
//   sweep_node   : node index of the current sweep step
module gam_bank_fsm
    import gam_memory_bank_pkg::*;
#(
    parameter int NUM_CLASSES     = 4,
    parameter int NODES_PER_CLASS = 8,
    parameter int CW              = $clog2(NUM_CLASSES),
    parameter int NW              = $clog2(NODES_PER_CLASS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  gam_op_e       req_op,
    input  logic          class_ok,
    output logic          req_ready,
    output logic          accept,
    output logic          init_busy,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [CW-1:0] sweep_class,
    output logic [NW-1:0] sweep_node
);

    localparam logic [CW-1:0] CLASS_LAST = CW'(NUM_CLASSES - 1);
    localparam logic [NW-1:0] NODE_LAST  = NW'(NODES_PER_CLASS - 1);

    gam_bank_state_e state, state_next;
    logic [CW-1:0]   sweep_class_next;
    logic [NW-1:0]   sweep_node_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            sweep_class <= '0;
            sweep_node  <= '0;
        end else begin
            state       <= state_next;
            sweep_class <= sweep_class_next;
            sweep_node  <= sweep_node_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next       = state;
        sweep_class_next = sweep_class;
        sweep_node_next  = sweep_node;
        req_ready        = 1'b0;
        accept           = 1'b0;
        init_busy        = 1'b0;
        clr_busy         = 1'b0;
        clr_done         = 1'b0;

        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                if (sweep_node == NODE_LAST) begin
                    sweep_node_next = '0;
                    if (sweep_class == CLASS_LAST) begin
                        sweep_class_next = '0;
                        state_next       = ST_IDLE;
                    end else begin
                        sweep_class_next = sweep_class + 1'b1;
                    end
                end else begin
                    sweep_node_next = sweep_node + 1'b1;
                end
            end

            ST_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                // An out-of-range CLEAR is answered with an error directly.
                if (req_valid && req_op == OP_CLEAR && class_ok) begin
                    state_next      = ST_CLR;
                    sweep_node_next = '0;
                end
            end

            ST_CLR: begin
                clr_busy = 1'b1;
                if (sweep_node == NODE_LAST) begin
                    sweep_node_next = '0;
                    clr_done        = 1'b1;
                    state_next      = ST_IDLE;
                end else begin
                    sweep_node_next = sweep_node + 1'b1;
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: rtl/gam_memory_bank.sv
// gam_memory_bank
// Clocked per-class node store for the GAM learning controller / classifier.
// Each class owns NODES_PER_CLASS node records {X, W, Th, M}, a class name and
// an occupancy count. One request per cycle over valid/ready, response one
// cycle later as a single-cycle rsp_valid pulse.
//   req_valid/req_ready : request handshake
//   req_op              : 0 READ, 1 WRITE, 2 ALLOC, 3 CLEAR
//   req_class/req_node  : entry address (req_node ignored by ALLOC/CLEAR)
//   req_fmask           : field select {M, T, W, C, X}
//   wr_x/wr_w/wr_th/wr_m: write data (C takes its value from wr_th)
//   rsp_valid/rsp_err   : response strobe and rejection flag
//   rsp_node            : allocated node for ALLOC, else echo of req_node
//   rsp_class/x/w/th/m  : selected fields, unselected fields read 0
//   rsp_count           : class occupancy after the operation
module gam_memory_bank
    import gam_memory_bank_pkg::*;
#(
    parameter int NUM_CLASSES     = 4,
    parameter int NODES_PER_CLASS = 8,
    parameter int DIM             = 4,
    parameter int DATA_W          = 16,
    parameter int CW              = $clog2(NUM_CLASSES),
    parameter int NW              = $clog2(NODES_PER_CLASS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [CW-1:0]         req_class,
    input  logic [NW-1:0]         req_node,
    input  logic [FM_BITS-1:0]    req_fmask,
    input  logic [DIM*DATA_W-1:0] wr_x,
    input  logic [DIM*DATA_W-1:0] wr_w,
    input  logic [DATA_W-1:0]     wr_th,
    input  logic [DATA_W-1:0]     wr_m,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [NW-1:0]         rsp_node,
    output logic [DATA_W-1:0]     rsp_class,
    output logic [DIM*DATA_W-1:0] rsp_x,
    output logic [DIM*DATA_W-1:0] rsp_w,
    output logic [DATA_W-1:0]     rsp_th,
    output logic [DATA_W-1:0]     rsp_m,
    output logic [NW:0]           rsp_count
);

    typedef struct packed {
        logic [DIM*DATA_W-1:0] x;
        logic [DIM*DATA_W-1:0] w;
        logic [DATA_W-1:0]     th;
        logic [DATA_W-1:0]     m;
    } node_t;

    localparam logic [CW:0] CLASS_LIMIT = (CW+1)'(NUM_CLASSES);
    localparam logic [NW:0] NODE_LIMIT  = (NW+1)'(NODES_PER_CLASS);

    node_t             mem        [NUM_CLASSES][NODES_PER_CLASS];
    logic [DATA_W-1:0] class_name [NUM_CLASSES];
    logic [NW:0]       count      [NUM_CLASSES];
    logic [CW-1:0]     clr_class;
    logic [NW-1:0]     clr_node;

    logic          accept, init_busy, clr_busy, clr_done;
    logic [CW-1:0] sweep_class;
    logic [NW-1:0] sweep_node;

    gam_op_e           op;
    logic              class_ok, node_ok, full;
    logic [CW-1:0]     cls;
    logic [NW:0]       cnt, cnt_after;
    logic [NW-1:0]     tgt_node;
    node_t             cur, post, rsp_rec;
    logic [DATA_W-1:0] post_name;
    logic              wr_ok, alloc_ok, op_err;

    assign op = gam_op_e'(req_op);

    gam_bank_fsm #(
        .NUM_CLASSES     (NUM_CLASSES),
        .NODES_PER_CLASS (NODES_PER_CLASS),
        .CW              (CW),
        .NW              (NW)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_op      (op),
        .class_ok    (class_ok),
        .req_ready   (req_ready),
        .accept      (accept),
        .init_busy   (init_busy),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .sweep_class (sweep_class),
        .sweep_node  (sweep_node)
    );

    // Request decode and the post-operation view of the addressed entry.
    always_comb begin
        class_ok = ({1'b0, req_class} < CLASS_LIMIT);
        cls      = class_ok ? req_class : '0;
        cnt      = count[cls];
        full     = (cnt == NODE_LIMIT);
        node_ok  = ({1'b0, req_node} < cnt);
        tgt_node = (op == OP_ALLOC) ? cnt[NW-1:0] : req_node;
        cur      = mem[cls][tgt_node];

        wr_ok    = accept && class_ok && (op == OP_WRITE) && node_ok;
        alloc_ok = accept && class_ok && (op == OP_ALLOC) && !full;

        op_err = 1'b0;
        case (op)
            OP_READ, OP_WRITE: op_err = !class_ok || !node_ok;
            OP_ALLOC:          op_err = !class_ok || full;
            OP_CLEAR:          op_err = !class_ok;
            default:           op_err = 1'b1;
        endcase

        // A freshly allocated node starts from zero before masked fields land.
        post = (op == OP_ALLOC) ? '0 : cur;
        if (wr_ok || alloc_ok) begin
            if (req_fmask[FM_X]) post.x  = wr_x;
            if (req_fmask[FM_W]) post.w  = wr_w;
            if (req_fmask[FM_T]) post.th = wr_th;
            if (req_fmask[FM_M]) post.m  = wr_m;
        end

        // The name belongs to the class, not to a node, so only WRITE
        // renames it; ALLOC leaves it alone.
        post_name = class_name[cls];
        if (wr_ok && req_fmask[FM_C]) post_name = wr_th;

        cnt_after = alloc_ok ? cnt + 1'b1 : cnt;

        rsp_rec = '0;
        if (req_fmask[FM_X]) rsp_rec.x  = post.x;
        if (req_fmask[FM_W]) rsp_rec.w  = post.w;
        if (req_fmask[FM_T]) rsp_rec.th = post.th;
        if (req_fmask[FM_M]) rsp_rec.m  = post.m;
    end

    // NOTE: the record arrays have no reset term; the INIT sweep that follows
    // every reset zeroes them, which keeps them mappable onto RAM.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[sweep_class][sweep_node] <= '0;
            class_name[sweep_class]      <= DATA_W'(sweep_class);
        end else if (clr_busy) begin
            mem[clr_class][sweep_node] <= '0;
        end else begin
            if (wr_ok || alloc_ok) mem[cls][tgt_node] <= post;
            if (wr_ok && req_fmask[FM_C]) class_name[cls] <= post_name;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) count[c] <= '0;
            clr_class <= '0;
            clr_node  <= '0;
        end else begin
            if (clr_busy && sweep_node == '0) begin
                count[clr_class] <= '0;
            end else if (alloc_ok) begin
                count[cls] <= cnt_after;
            end
            if (accept && op == OP_CLEAR) begin
                clr_class <= cls;
                clr_node  <= req_node;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_node  <= '0;
            rsp_class <= '0;
            rsp_x     <= '0;
            rsp_w     <= '0;
            rsp_th    <= '0;
            rsp_m     <= '0;
            rsp_count <= '0;
        end else begin
            rsp_valid <= 1'b0;
            // A valid CLEAR answers from clr_done at the end of its sweep.
            if (accept && !(op == OP_CLEAR && class_ok)) begin
                rsp_valid <= 1'b1;
                rsp_err   <= op_err;
                rsp_node  <= alloc_ok ? cnt[NW-1:0] : req_node;
                rsp_count <= class_ok ? cnt_after : '0;
                if (op_err || op == OP_CLEAR) begin
                    rsp_class <= '0;
                    rsp_x     <= '0;
                    rsp_w     <= '0;
                    rsp_th    <= '0;
                    rsp_m     <= '0;
                end else begin
                    rsp_class <= req_fmask[FM_C] ? post_name : '0;
                    rsp_x     <= rsp_rec.x;
                    rsp_w     <= rsp_rec.w;
                    rsp_th    <= rsp_rec.th;
                    rsp_m     <= rsp_rec.m;
                end
            end else if (clr_done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_node  <= clr_node;
                rsp_class <= '0;
                rsp_x     <= '0;
                rsp_w     <= '0;
                rsp_th    <= '0;
                rsp_m     <= '0;
                rsp_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gam_memory_bank.sv
// tb_gam_memory_bank
// Directed self-checking bench for gam_memory_bank at default parameters.
module tb_gam_memory_bank;
    import gam_memory_bank_pkg::*;

    localparam int NUM_CLASSES     = 4;
    localparam int NODES_PER_CLASS = 8;
    localparam int DIM             = 4;
    localparam int DATA_W          = 16;
    localparam int CW              = 2;
    localparam int NW              = 3;
    localparam int VW              = DIM * DATA_W;

    localparam logic [VW-1:0] X1 = {16'd1, 16'd2, 16'd3, 16'd4};
    localparam logic [VW-1:0] W1 = {16'd10, 16'd20, 16'd30, 16'd40};
    localparam logic [VW-1:0] X2 = {16'd9, 16'd9, 16'd9, 16'd9};

    localparam logic [4:0] FM_ALL  = 5'b11111;
    localparam logic [4:0] FM_XCWT = 5'b01111;
    localparam logic [4:0] FM_MO   = 5'b10000;
    localparam logic [4:0] FM_XO   = 5'b00001;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [CW-1:0]   req_class;
    logic [NW-1:0]   req_node;
    logic [4:0]      req_fmask;
    logic [VW-1:0]   wr_x;
    logic [VW-1:0]   wr_w;
    logic [DATA_W-1:0] wr_th;
    logic [DATA_W-1:0] wr_m;
    logic            rsp_valid;
    logic            rsp_err;
    logic [NW-1:0]   rsp_node;
    logic [DATA_W-1:0] rsp_class;
    logic [VW-1:0]   rsp_x;
    logic [VW-1:0]   rsp_w;
    logic [DATA_W-1:0] rsp_th;
    logic [DATA_W-1:0] rsp_m;
    logic [NW:0]     rsp_count;

    int n_checks = 0;
    int n_errors = 0;

    gam_memory_bank #(
        .NUM_CLASSES     (NUM_CLASSES),
        .NODES_PER_CLASS (NODES_PER_CLASS),
        .DIM             (DIM),
        .DATA_W          (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_class (req_class),
        .req_node  (req_node),
        .req_fmask (req_fmask),
        .wr_x      (wr_x),
        .wr_w      (wr_w),
        .wr_th     (wr_th),
        .wr_m      (wr_m),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_node  (rsp_node),
        .rsp_class (rsp_class),
        .rsp_x     (rsp_x),
        .rsp_w     (rsp_w),
        .rsp_th    (rsp_th),
        .rsp_m     (rsp_m),
        .rsp_count (rsp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request at the falling edge; return 1 ns after the accepting
    // rising edge, when the response registers are already visible.
    task automatic send(input gam_op_e op, input int cls, input int node,
                        input logic [4:0] fm, input logic [VW-1:0] x,
                        input logic [VW-1:0] w, input logic [DATA_W-1:0] th,
                        input logic [DATA_W-1:0] m);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_class = CW'(cls);
        req_node  = NW'(node);
        req_fmask = fm;
        wr_x      = x;
        wr_w      = w;
        wr_th     = th;
        wr_m      = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count rising edges until req_ready rises; bounded so the bench always ends.
    task automatic wait_ready(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(n), 64'(exp_cycles));
    endtask

    initial begin
        int cyc;
        int low;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_class = '0;
        req_node  = '0;
        req_fmask = '0;
        wr_x      = '0;
        wr_w      = '0;
        wr_th     = '0;
        wr_m      = '0;

        // Reset and INIT sweep length.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_count", rsp_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init_cycles", 32);

        send(OP_READ, 2, 0, FM_ALL, '0, '0, '0, '0);
        check("rd_empty_valid", rsp_valid, 1);
        check("rd_empty_err", rsp_err, 1);
        check("rd_empty_count", rsp_count, 0);

        // ALLOC into class 1.
        send(OP_ALLOC, 1, 5, FM_XCWT, X1, W1, 16'd7, 16'd55);
        check("alloc_valid", rsp_valid, 1);
        check("alloc_err", rsp_err, 0);
        check("alloc_node", rsp_node, 0);
        check("alloc_count", rsp_count, 1);
        check("alloc_x", rsp_x, X1);
        check("alloc_m_unsel", rsp_m, 0);
        @(posedge clk);
        #1;
        check("rsp_pulse", rsp_valid, 0);

        send(OP_READ, 1, 0, FM_ALL, '0, '0, '0, '0);
        check("rd1_err", rsp_err, 0);
        check("rd1_x", rsp_x, X1);
        check("rd1_w", rsp_w, W1);
        check("rd1_th", rsp_th, 7);
        check("rd1_m", rsp_m, 0);
        check("rd1_class", rsp_class, 1);
        check("rd1_count", rsp_count, 1);

        // Fill class 3, then overflow it.
        for (int i = 0; i < 9; i++) begin
            send(OP_ALLOC, 3, 0, FM_MO, '0, '0, '0, 16'(100 + i));
            if (i < NODES_PER_CLASS) begin
                check("fill_node", rsp_node, 64'(i));
                check("fill_count", rsp_count, 64'(i + 1));
                check("fill_err", rsp_err, 0);
            end else begin
                check("full_err", rsp_err, 1);
                check("full_count", rsp_count, 8);
            end
        end
        send(OP_READ, 3, 7, FM_MO, '0, '0, '0, '0);
        check("rd3_m", rsp_m, 107);
        check("rd3_x_unsel", rsp_x, 0);

        // Masked write touches only M.
        send(OP_WRITE, 1, 0, FM_MO, X2, '0, 16'd99, 16'd42);
        check("mw_err", rsp_err, 0);
        check("mw_m", rsp_m, 42);
        send(OP_READ, 1, 0, FM_ALL, '0, '0, '0, '0);
        check("mw_rd_m", rsp_m, 42);
        check("mw_rd_th", rsp_th, 7);
        check("mw_rd_x", rsp_x, X1);

        // Write beyond occupancy is rejected.
        send(OP_WRITE, 1, 3, FM_ALL, X2, X2, 16'd1, 16'd1);
        check("wr_oor_err", rsp_err, 1);
        check("wr_oor_x", rsp_x, 0);

        // CLEAR class 3.
        send(OP_CLEAR, 3, 2, FM_ALL, '0, '0, '0, '0);
        cyc = 0;
        low = 0;
        while (rsp_valid !== 1'b1 && cyc < 50) begin
            if (req_ready === 1'b0) low++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("clr_cycles", 64'(cyc), 8);
        check("clr_ready_low", 64'(low), 8);
        check("clr_ready_back", req_ready, 1);
        check("clr_err", rsp_err, 0);
        check("clr_count", rsp_count, 0);
        send(OP_READ, 3, 5, FM_ALL, '0, '0, '0, '0);
        check("clr_rd_err", rsp_err, 1);
        check("clr_rd_count", rsp_count, 0);
        send(OP_READ, 1, 0, FM_ALL, '0, '0, '0, '0);
        check("c1_keep_x", rsp_x, X1);
        check("c1_keep_m", rsp_m, 42);

        // Consecutive WRITE then READ of the same entry.
        send(OP_WRITE, 1, 0, FM_XO, X2, '0, '0, '0);
        check("b2b_wr_x", rsp_x, X2);
        send(OP_READ, 1, 0, FM_ALL, '0, '0, '0, '0);
        check("b2b_rd_valid", rsp_valid, 1);
        check("b2b_rd_x", rsp_x, X2);
        check("b2b_rd_th", rsp_th, 7);

        // Reset in the middle of a CLEAR sweep.
        send(OP_ALLOC, 2, 0, FM_ALL, X1, '0, '0, '0);
        check("c2_alloc_count", rsp_count, 1);
        send(OP_CLEAR, 2, 0, FM_ALL, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reinit_cycles", 32);
        send(OP_READ, 2, 0, FM_ALL, '0, '0, '0, '0);
        check("reinit_c2_err", rsp_err, 1);
        check("reinit_c2_count", rsp_count, 0);
        send(OP_READ, 1, 0, FM_ALL, '0, '0, '0, '0);
        check("reinit_c1_err", rsp_err, 1);
        check("reinit_c1_count", rsp_count, 0);
        send(OP_ALLOC, 1, 0, FM_ALL, '0, '0, '0, '0);
        check("reinit_alloc_node", rsp_node, 0);
        check("reinit_alloc_count", rsp_count, 1);
        check("reinit_alloc_class", rsp_class, 1);
        check("reinit_alloc_x", rsp_x, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gam_memory_bank.md
Name: gam_memory_bank

Overview:
- Clocked, parametrised successor to the GAM combinational memory layer.
- Stores per-class node records: X vector, W vector, threshold Th and match count M, plus a class name and a per-class node occupancy count.
- Accepts one request per cycle over a valid/ready handshake: READ, WRITE, ALLOC (append a node) or CLEAR (empty one class).
- Field-select mask replaces the legacy X_c/C_c/W_c/T_c/M_c strobes; sits between the GAM learning controller and the classifier datapath.

Parameters:
- NUM_CLASSES, 4, number of classes
- NODES_PER_CLASS, 8, node slots per class
- DIM, 4, elements per X/W vector
- DATA_W, 16, bits per vector element, Th, M and class name
- CW, $clog2(NUM_CLASSES), class index width (derived)
- NW, $clog2(NODES_PER_CLASS), node index width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  block can accept a request
- req_op  in  2  0 READ, 1 WRITE, 2 ALLOC, 3 CLEAR
- req_class  in  CW  class index
- req_node  in  NW  node index; ignored for ALLOC/CLEAR
- req_fmask  in  5  field select {M,T,W,C,X}, bit0 = X
- wr_x  in  DIM*DATA_W  X write data
- wr_w  in  DIM*DATA_W  W write data
- wr_th  in  DATA_W  Th write data
- wr_m  in  DATA_W  M write data
- rsp_valid  out  1  response valid, single-cycle pulse
- rsp_err  out  1  request rejected
- rsp_node  out  NW  node index (ALLOC result, else echo of req_node)
- rsp_class  out  DATA_W  class name
- rsp_x  out  DIM*DATA_W  X read data
- rsp_w  out  DIM*DATA_W  W read data
- rsp_th  out  DATA_W  Th read data
- rsp_m  out  DATA_W  M read data
- rsp_count  out  NW+1  class occupancy after the operation

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: all rsp_* outputs 0; req_ready 0; all counts 0; FSM enters INIT.
- INIT state:
  - Sweeps every class/node entry, one per cycle (NUM_CLASSES*NODES_PER_CLASS cycles), zeroing all fields.
  - Writes class name = class index.
  - Then goes to IDLE with req_ready=1.
- IDLE state:
  - Request accepted when req_valid && req_ready.
  - Response on the next cycle: rsp_valid=1 for one cycle. Latency is 1.
  - Back-to-back requests accepted every cycle.
- READ:
  - Fields selected by req_fmask are returned; unselected fields read 0.
  - req_node >= count[class] -> rsp_err=1, all data 0.
- WRITE:
  - Only fields selected by req_fmask are updated; C writes the class name from wr_th[DATA_W-1:0].
  - Node out of occupancy -> rsp_err=1, no write.
  - Response data is the post-write value (write-first).
- ALLOC:
  - If count < NODES_PER_CLASS: node = count; all fields zeroed, then fmask fields written; count++; rsp_node = node.
  - Otherwise (class full): rsp_err=1, no state change.
- CLEAR:
  - FSM goes to CLR, req_ready=0 for NODES_PER_CLASS cycles, zeroing each node of the class.
  - count is set to 0 on the first CLR cycle.
  - rsp_valid is asserted on the cycle the FSM returns to IDLE.
- Out-of-range req_class (class >= NUM_CLASSES, non-power-of-2 case) -> rsp_err=1 for all ops, no state change.
- Same-cycle accepted request following a write to the same entry sees the new data; there is no stale bypass window.
- rst_n low mid-CLR or mid-INIT: restarts INIT from entry 0. Any pending response is dropped (rsp_valid=0).
- Storage is flop- or RAM-inferred with a registered read. Arithmetic is unsigned; count never wraps.

Decomposition:
- GAM_package gains:
  - gam_op_e enum (READ, WRITE, ALLOC, CLEAR)
  - field-mask bit constants FM_X..FM_M
  - parametrised node record struct {X, W, Th, M}
- The existing RD_WR_T type stays for legacy users.
- Sub-module gam_bank_fsm owns INIT/IDLE/CLR sequencing, the sweep counter and req_ready.
- The top level holds the storage arrays and count registers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> req_ready=0 for 32 cycles, then 1. READ class 2 node 0 -> rsp_err=1 (count 0).
- ALLOC: ALLOC class 1, fmask=5'b01111, wr_x={1,2,3,4}, wr_th=7 -> next cycle rsp_node=0, rsp_count=1. READ of node 0 with fmask all -> x={1,2,3,4}, th=7, m=0, class=1.
- Full class: 9 ALLOCs to class 3 -> first 8 give rsp_node 0..7, 9th gives rsp_err=1, rsp_count stays 8.
- Masked write: WRITE class 1 node 0, fmask=FM_M only, wr_m=42, wr_th=99 -> READ returns m=42, th=7.
- CLEAR: CLEAR class 3 -> req_ready low 8 cycles, then rsp_valid. READ class 3 node 5 -> rsp_err. Class 1 data unchanged.
- Pipelining and reset: back-to-back WRITE then READ of the same entry on consecutive cycles -> READ returns new data. Assert rst_n=0 during a CLEAR -> INIT restarts, all counts 0.
